count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 125 ++++++++++++
 tb/tb_count_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Monitors a free-running 4-bit upstream counter: detects steps, acquires lock
// on consecutive +1 steps, and flags bad steps or stalls while locked.
module count_monitor #(
    parameter int LOCK_N    = 4,
    parameter int STALL_MAX = 8
) (
    input  logic       clk_100M,
    input  logic       rst_,
    input  logic [3:0] cnt_in,
    input  logic       clr,
    output logic       step_pulse,
    output logic       lock,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [3:0] period
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, ERR} state_t;

    localparam logic [3:0] LOCK_V  = 4'(LOCK_N);
    localparam logic [3:0] STALL_V = 4'(STALL_MAX - 1);

    state_t     state;
    logic [3:0] cnt_q;
    logic [3:0] prev_q;
    logic       chg_q;
    logic       good_q;
    logic [3:0] gap_cnt;
    logic [3:0] good_run;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk_100M or negedge rst_) begin
        if (!rst_) begin
            cnt_q      <= '0;
            prev_q     <= '0;
            chg_q      <= 1'b0;
            good_q     <= 1'b0;
            gap_cnt    <= '0;
            good_run   <= '0;
            state      <= IDLE;
            step_pulse <= 1'b0;
            lock       <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            period     <= '0;
        end else begin
            cnt_q  <= cnt_in;
            prev_q <= cnt_q;
            // Compare result is registered so the FSM sees it two edges after sampling.
            chg_q  <= (cnt_q != prev_q);
            good_q <= (cnt_q == prev_q + 4'd1);

            if (chg_q) begin
                period  <= gap_cnt;
                gap_cnt <= 4'd1;
            end else begin
                gap_cnt <= sat_inc4(gap_cnt);
            end

            step_pulse <= chg_q && (state != IDLE);
            err_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    good_run <= '0;
                    lock     <= 1'b0;
                    state    <= ACQ;
                end
                ACQ: begin
                    if (chg_q && good_q) begin
                        good_run <= good_run + 4'd1;
                        if (good_run + 4'd1 == LOCK_V) begin
                            state <= LOCKED;
                            lock  <= 1'b1;
                        end
                    end else if (chg_q) begin
                        good_run <= '0;
                    end
                end
                LOCKED: begin
                    // Entering ERR on a stall makes it a one-shot per episode.
                    if ((chg_q && !good_q) || (!chg_q && gap_cnt == STALL_V)) begin
                        state     <= ERR;
                        lock      <= 1'b0;
                        err_pulse <= 1'b1;
                        err_cnt   <= sat_inc8(err_cnt);
                    end
                end
                ERR: begin
                    if (chg_q && good_q) begin
                        good_run <= 4'd1;
                        if (LOCK_V == 4'd1) begin
                            state <= LOCKED;
                            lock  <= 1'b1;
                        end else begin
                            state <= ACQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    lock  <= 1'b0;
                end
            endcase

            // Clear overrides any error detected in the same cycle.
            if (clr) begin
                err_cnt   <= '0;
                period    <= '0;
                good_run  <= '0;
                state     <= ACQ;
                lock      <= 1'b0;
                err_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed scoreboard bench for count_monitor: expectations are queued with
// the cycle at which they must be seen and compared on the falling edge.
module tb_count_monitor;

    localparam int S_STEP = 0;
    localparam int S_LOCK = 1;
    localparam int S_ERRP = 2;
    localparam int S_ERRC = 3;
    localparam int S_PER  = 4;

    typedef struct {
        int at;
        int sel;
        int val;
    } exp_t;

    logic       clk_100M = 1'b0;
    logic       rst_;
    logic [3:0] cnt_in;
    logic       clr;
    logic       step_pulse;
    logic       lock;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [3:0] period;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    count_monitor #(.LOCK_N(4), .STALL_MAX(8)) dut (
        .clk_100M  (clk_100M),
        .rst_      (rst_),
        .cnt_in    (cnt_in),
        .clr       (clr),
        .step_pulse(step_pulse),
        .lock      (lock),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .period    (period)
    );

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    function automatic string sel_name(input int sel);
        case (sel)
            S_STEP:  return "step_pulse";
            S_LOCK:  return "lock";
            S_ERRP:  return "err_pulse";
            S_ERRC:  return "err_cnt";
            default: return "period";
        endcase
    endfunction

    function automatic int pick(input int sel);
        case (sel)
            S_STEP:  return int'(step_pulse);
            S_LOCK:  return int'(lock);
            S_ERRP:  return int'(err_pulse);
            S_ERRC:  return int'(err_cnt);
            default: return int'(period);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, req);
        end
    endtask

    task automatic want(input int dly, input int sel, input int val);
        exp_t e;
        e.at  = cyc + dly;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic slot(input logic [3:0] v, input logic c);
        @(negedge clk_100M);
        cnt_in = v;
        clr    = c;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".step_pulse"}, int'(step_pulse), 0);
        chk({tag, ".lock"},       int'(lock),       0);
        chk({tag, ".err_pulse"},  int'(err_pulse),  0);
        chk({tag, ".err_cnt"},    int'(err_cnt),    0);
        chk({tag, ".period"},     int'(period),     0);
    endtask

    always @(negedge clk_100M) begin
        if (rst_ === 1'b1) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    chk(sel_name(sb[i].sel), pick(sb[i].sel), sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] v;
        int         ec;

        rst_   = 1'b0;
        cnt_in = 4'd0;
        clr    = 1'b0;
        repeat (3) @(negedge clk_100M);
        chk_all_zero("reset");
        rst_ = 1'b1;
        repeat (3) slot(4'd0, 1'b0);

        // Steady +1 every two cycles, across the 15->0 wrap.
        v = 4'd0;
        for (int i = 1; i <= 19; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            want(3, S_STEP, 1);
            want(3, S_LOCK, (i >= 4) ? 1 : 0);
            want(3, S_ERRP, 0);
            want(3, S_ERRC, 0);
            if (i >= 2) want(3, S_PER, 2);
            slot(v, 1'b0);
            want(3, S_STEP, 0);
        end

        // Jump 5->7 while locked, then re-acquire on 8..11.
        for (int i = 0; i < 2; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            slot(v, 1'b0);
        end
        v = v + 4'd2;
        slot(v, 1'b0);
        want(3, S_ERRP, 1);
        want(3, S_ERRC, 1);
        want(3, S_LOCK, 0);
        want(3, S_STEP, 1);
        slot(v, 1'b0);
        want(3, S_ERRP, 0);
        for (int i = 1; i <= 4; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            want(3, S_LOCK, (i == 4) ? 1 : 0);
            want(3, S_ERRP, 0);
            want(3, S_ERRC, 1);
            slot(v, 1'b0);
        end

        // Advance to 9 while locked, then hold it for 20 cycles.
        for (int i = 0; i < 13; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            slot(v, 1'b0);
        end
        v = v + 4'd1;
        slot(v, 1'b0);
        want(3, S_PER, 2);
        want(3, S_LOCK, 1);
        for (int j = 1; j <= 19; j++) begin
            slot(v, 1'b0);
            want(3, S_ERRP, (j == 7) ? 1 : 0);
            want(3, S_ERRC, (j < 7) ? 1 : 2);
            want(3, S_LOCK, (j < 7) ? 1 : 0);
            want(3, S_PER, 2);
        end
        for (int i = 1; i <= 4; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            if (i == 1) want(3, S_PER, 15);
            want(3, S_LOCK, (i == 4) ? 1 : 0);
            want(3, S_ERRP, 0);
            slot(v, 1'b0);
        end

        // 300 error/relock episodes drive err_cnt into saturation.
        ec = 2;
        for (int e = 1; e <= 300; e++) begin
            v = v + 4'd2;
            slot(v, 1'b0);
            ec = (ec < 255) ? ec + 1 : 255;
            want(3, S_ERRP, 1);
            want(3, S_ERRC, ec);
            want(3, S_LOCK, 0);
            for (int g = 1; g <= 4; g++) begin
                v = v + 4'd1;
                slot(v, 1'b0);
                want(3, S_LOCK, (g == 4) ? 1 : 0);
                want(3, S_ERRP, 0);
            end
        end

        // Clear coincident with a bad step while locked.
        v = v + 4'd2;
        slot(v, 1'b0);
        want(3, S_ERRP, 0);
        want(3, S_ERRC, 0);
        want(3, S_LOCK, 0);
        want(3, S_PER, 0);
        slot(v, 1'b0);
        slot(v, 1'b1);
        slot(v, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            want(3, S_LOCK, (i == 4) ? 1 : 0);
            want(3, S_ERRC, 0);
            slot(v, 1'b0);
        end

        // Three errors, relocked, then asynchronous reset between edges.
        for (int e = 1; e <= 3; e++) begin
            v = v + 4'd2;
            slot(v, 1'b0);
            want(3, S_ERRC, e);
            for (int g = 1; g <= 4; g++) begin
                v = v + 4'd1;
                slot(v, 1'b0);
                want(3, S_LOCK, (g == 4) ? 1 : 0);
            end
        end
        repeat (4) slot(v, 1'b0);
        #1;
        rst_   = 1'b0;
        cnt_in = 4'd0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(negedge clk_100M);
        rst_ = 1'b1;
        repeat (2) slot(4'd0, 1'b0);
        v = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            v = v + 4'd1;
            slot(v, 1'b0);
            want(3, S_LOCK, (i == 4) ? 1 : 0);
            want(3, S_ERRC, 0);
            want(3, S_STEP, 1);
            if (i >= 2) want(3, S_PER, 2);
            slot(v, 1'b0);
        end
        repeat (4) slot(v, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
